// File: rtl/lsu_mem_if.sv
// Data-memory request/acknowledge bus between the load/store unit (master)
// and the memory (slave).
interface lsu_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store stage: one access per start over a req/ack memory bus.
// Define LSU_TIMEOUT_EN to add the TIMEOUT_CYCLES request watchdog and timeout flag.
module load_store_unit
`ifdef LSU_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 255)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        illegal,
  lsu_mem_if.master   mem
`ifdef LSU_TIMEOUT_EN
  ,
  output logic        timeout
`endif
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        misaligned_q, misaligned_d, illegal_q, illegal_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;

  logic        req_illegal, req_misaligned;
  logic [3:0]  st_wmask;
  logic [31:0] st_wdata;
  logic [15:0] load_shift;
  logic [31:0] load_ext;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  // Request decode and store lane steering, evaluated on the live inputs.
  always_comb begin
    if (is_store)
      req_illegal = funct3[2] || (funct3[1:0] == 2'b11);
    else
      req_illegal = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
    req_misaligned = !req_illegal &&
                     (((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));
    case (funct3[1:0])
      2'b00: begin
        st_wmask = 4'b0001 << addr[1:0];
        st_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_wmask = addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{wdata[15:0]}};
      end
      default: begin
        st_wmask = 4'b1111;
        st_wdata = wdata;
      end
    endcase
  end

  // funct3[2] marks the unsigned load variants.
  always_comb begin
    load_shift = 16'(mem.mem_rdata >> {off_q, 3'b000});
    case (funct3_q[1:0])
      2'b00:   load_ext = {{24{load_shift[7] & ~funct3_q[2]}}, load_shift[7:0]};
      2'b01:   load_ext = {{16{load_shift[15] & ~funct3_q[2]}}, load_shift[15:0]};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    misaligned_d = misaligned_q;
    illegal_d    = illegal_q;
    rdata_d      = rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wmask_d  = mem_wmask_q;
    mem_wdata_d  = mem_wdata_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    off_d        = off_q;
`ifdef LSU_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    timeout_d    = timeout_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d       = 1'b1;
          is_store_d   = is_store;
          funct3_d     = funct3;
          off_d        = addr[1:0];
          illegal_d    = req_illegal;
          misaligned_d = req_misaligned;
`ifdef LSU_TIMEOUT_EN
          to_cnt_d     = '0;
          timeout_d    = 1'b0;
`endif
          if (req_illegal || req_misaligned) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wmask_d = is_store ? st_wmask : 4'b0000;
            mem_wdata_d = is_store ? st_wdata : 32'h0;
          end
        end
      end
      ACCESS: begin
        if (mem.mem_ack) begin
          state_d     = DONE;
          done_d      = 1'b1;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wmask_d = 4'b0000;
          if (!is_store_q)
            rdata_d = load_ext;
        end
`ifdef LSU_TIMEOUT_EN
        else if (to_cnt_q == TO_LIMIT) begin
          state_d     = DONE;
          done_d      = 1'b1;
          timeout_d   = 1'b1;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wmask_d = 4'b0000;
        end else begin
          to_cnt_d = to_cnt_q + CNT_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      illegal_q    <= 1'b0;
      rdata_q      <= 32'h0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wmask_q  <= 4'b0000;
      mem_wdata_q  <= 32'h0;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b000;
      off_q        <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      to_cnt_q     <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      misaligned_q <= misaligned_d;
      illegal_q    <= illegal_d;
      rdata_q      <= rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wmask_q  <= mem_wmask_d;
      mem_wdata_q  <= mem_wdata_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
`ifdef LSU_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign rdata         = rdata_q;
  assign misaligned    = misaligned_q;
  assign illegal       = illegal_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wmask = mem_wmask_q;
  assign mem.mem_wdata = mem_wdata_q;
`ifdef LSU_TIMEOUT_EN
  assign timeout       = timeout_q;
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit; covers the timeout path when LSU_TIMEOUT_EN is defined.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, misaligned, illegal;
  logic [31:0] rdata;
`ifdef LSU_TIMEOUT_EN
  logic        timeout;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  lsu_mem_if lsu_bus ();

`ifdef LSU_TIMEOUT_EN
  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .misaligned(misaligned), .illegal(illegal),
    .mem(lsu_bus), .timeout(timeout));
`else
  load_store_unit dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .misaligned(misaligned), .illegal(illegal),
    .mem(lsu_bus));
`endif

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Load vectors: funct3, address, memory word, expected word address, expected rdata.
  logic [2:0]  ld_f3    [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b010};
  logic [31:0] ld_addr  [6] = '{32'h1003, 32'h1003, 32'h1002, 32'h1002, 32'h1001, 32'h1000};
  logic [31:0] ld_mem   [6] = '{32'h80FF_1234, 32'h80FF_1234, 32'h80FF_1234,
                                32'h80FF_1234, 32'h80FF_1234, 32'h80FF_1234};
  logic [31:0] ld_waddr [6] = '{32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1000, 32'h1000};
  logic [31:0] ld_exp   [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF,
                                32'h0000_80FF, 32'h0000_0012, 32'h80FF_1234};

  // Store vectors: funct3, address, data, wait cycles, expected word address, mask, lane data.
  logic [2:0]  st_f3    [4] = '{3'b001, 3'b000, 3'b010, 3'b001};
  logic [31:0] st_addr  [4] = '{32'h2002, 32'h2001, 32'h2004, 32'h2000};
  logic [31:0] st_data  [4] = '{32'h1234_ABCD, 32'h0000_00CD, 32'hDEAD_BEEF, 32'h5555_7777};
  int          st_wait  [4] = '{3, 0, 1, 0};
  logic [31:0] st_waddr [4] = '{32'h2000, 32'h2000, 32'h2004, 32'h2000};
  logic [3:0]  st_mask  [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b0011};
  logic [31:0] st_wd    [4] = '{32'hABCD_ABCD, 32'hCDCD_CDCD, 32'hDEAD_BEEF, 32'h7777_7777};

  // Fault vectors: is_store, funct3, address, expected misaligned, expected illegal.
  logic        ft_st    [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [2:0]  ft_f3    [6] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110};
  logic [31:0] ft_addr  [6] = '{32'h3001, 32'h3003, 32'h3002, 32'h3001, 32'h3000, 32'h3000};
  logic        ft_mis   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        ft_ill   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({busy, done, misaligned, illegal, lsu_bus.mem_req, lsu_bus.mem_we} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b want 000000",
               {busy, done, misaligned, illegal, lsu_bus.mem_req, lsu_bus.mem_we});
    end
    tests_run++;
    if (rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_rdata: got %h want 00000000", rdata);
    end
    tests_run++;
    if ({lsu_bus.mem_addr, lsu_bus.mem_wdata, lsu_bus.mem_wmask} !== 68'h0) begin
      tests_failed++;
      $display("FAIL reset_bus: addr %h wdata %h wmask %b want all 0",
               lsu_bus.mem_addr, lsu_bus.mem_wdata, lsu_bus.mem_wmask);
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if ({busy, done, lsu_bus.mem_req} !== 3'b0) begin
      tests_failed++;
      $display("FAIL reset_release_idle: got %b want 000", {busy, done, lsu_bus.mem_req});
    end
  endtask

  task automatic test_load;
    for (int i = 0; i < 6; i++) begin
      is_store = 1'b0;
      funct3   = ld_f3[i];
      addr     = ld_addr[i];
      wdata    = 32'hFFFF_FFFF;
      start    = 1'b1;
      tick();
      start = 1'b0;
      tests_run++;
      if ({lsu_bus.mem_req, lsu_bus.mem_we, busy, done} !== 4'b1010) begin
        tests_failed++;
        $display("FAIL ld_req[%0d]: req/we/busy/done got %b want 1010", i,
                 {lsu_bus.mem_req, lsu_bus.mem_we, busy, done});
      end
      tests_run++;
      if (lsu_bus.mem_addr !== ld_waddr[i] || lsu_bus.mem_wmask !== 4'b0000) begin
        tests_failed++;
        $display("FAIL ld_addr[%0d]: addr %h mask %b want %h 0000", i,
                 lsu_bus.mem_addr, lsu_bus.mem_wmask, ld_waddr[i]);
      end
      lsu_bus.mem_ack   = 1'b1;
      lsu_bus.mem_rdata = ld_mem[i];
      tick();
      lsu_bus.mem_ack   = 1'b0;
      lsu_bus.mem_rdata = 32'h0;
      tests_run++;
      if ({done, busy, lsu_bus.mem_req, misaligned, illegal} !== 5'b11000) begin
        tests_failed++;
        $display("FAIL ld_done[%0d]: done/busy/req/mis/ill got %b want 11000", i,
                 {done, busy, lsu_bus.mem_req, misaligned, illegal});
      end
      tests_run++;
      if (rdata !== ld_exp[i]) begin
        tests_failed++;
        $display("FAIL ld_rdata[%0d]: got %h want %h", i, rdata, ld_exp[i]);
      end
      tick();
      tests_run++;
      if ({done, busy} !== 2'b00) begin
        tests_failed++;
        $display("FAIL ld_after[%0d]: done/busy got %b want 00", i, {done, busy});
      end
    end
  endtask

  // Start is held high with junk inputs during ACCESS; none of it may leak into the request.
  task automatic test_store;
    int n_done;
    for (int i = 0; i < 4; i++) begin
      n_done   = 0;
      is_store = 1'b1;
      funct3   = st_f3[i];
      addr     = st_addr[i];
      wdata    = st_data[i];
      start    = 1'b1;
      tick();
      addr   = 32'hFFFF_FFFF;
      funct3 = 3'b011;
      wdata  = 32'h0;
      for (int j = 0; j <= st_wait[i]; j++) begin
        tests_run++;
        if ({lsu_bus.mem_req, lsu_bus.mem_we} !== 2'b11 || lsu_bus.mem_addr !== st_waddr[i] ||
            lsu_bus.mem_wmask !== st_mask[i] || lsu_bus.mem_wdata !== st_wd[i]) begin
          tests_failed++;
          $display("FAIL st_req[%0d.%0d]: req %b we %b addr %h mask %b wdata %h want 1 1 %h %b %h",
                   i, j, lsu_bus.mem_req, lsu_bus.mem_we, lsu_bus.mem_addr, lsu_bus.mem_wmask,
                   lsu_bus.mem_wdata, st_waddr[i], st_mask[i], st_wd[i]);
        end
        if (done) n_done++;
        if (j == st_wait[i]) lsu_bus.mem_ack = 1'b1;
        tick();
      end
      lsu_bus.mem_ack = 1'b0;
      start = 1'b0;
      if (done) n_done++;
      tests_run++;
      if ({lsu_bus.mem_req, busy} !== 2'b01 || rdata !== 32'h80FF_1234) begin
        tests_failed++;
        $display("FAIL st_done[%0d]: req %b busy %b rdata %h want 0 1 80ff1234",
                 i, lsu_bus.mem_req, busy, rdata);
      end
      tick();
      if (done) n_done++;
      tests_run++;
      if (n_done != 1 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL st_once[%0d]: done pulses %0d busy %b want 1 0", i, n_done, busy);
      end
    end
  endtask

  task automatic test_fault;
    for (int i = 0; i < 6; i++) begin
      is_store = ft_st[i];
      funct3   = ft_f3[i];
      addr     = ft_addr[i];
      wdata    = 32'h1111_1111;
      start    = 1'b1;
      tick();
      start = 1'b0;
      tests_run++;
      if ({done, busy, lsu_bus.mem_req, misaligned, illegal} !== {3'b110, ft_mis[i], ft_ill[i]}) begin
        tests_failed++;
        $display("FAIL fault[%0d]: done/busy/req/mis/ill got %b want %b", i,
                 {done, busy, lsu_bus.mem_req, misaligned, illegal},
                 {3'b110, ft_mis[i], ft_ill[i]});
      end
      tests_run++;
      if (rdata !== 32'h80FF_1234) begin
        tests_failed++;
        $display("FAIL fault_rdata[%0d]: got %h want 80ff1234", i, rdata);
      end
      tick();
      tests_run++;
      if ({done, busy, lsu_bus.mem_req} !== 3'b000) begin
        tests_failed++;
        $display("FAIL fault_after[%0d]: done/busy/req got %b want 000", i,
                 {done, busy, lsu_bus.mem_req});
      end
    end
  endtask

  // start stays high throughout; the DONE-cycle start must be dropped, the next IDLE one taken.
  task automatic test_back_to_back;
    is_store = 1'b0;
    funct3   = 3'b000;
    addr     = 32'h0000_1000;
    start    = 1'b1;
    tick();
    tests_run++;
    if ({lsu_bus.mem_req, busy} !== 2'b11) begin
      tests_failed++;
      $display("FAIL b2b_req1: req/busy got %b want 11", {lsu_bus.mem_req, busy});
    end
    lsu_bus.mem_ack   = 1'b1;
    lsu_bus.mem_rdata = 32'h1122_3344;
    tick();
    lsu_bus.mem_ack = 1'b0;
    tests_run++;
    if ({done, lsu_bus.mem_req, illegal, misaligned} !== 4'b1000 || rdata !== 32'h0000_0044) begin
      tests_failed++;
      $display("FAIL b2b_done1: done/req/ill/mis %b rdata %h want 1000 00000044",
               {done, lsu_bus.mem_req, illegal, misaligned}, rdata);
    end
    tick();
    tests_run++;
    if ({done, busy, lsu_bus.mem_req} !== 3'b000) begin
      tests_failed++;
      $display("FAIL b2b_gap: done/busy/req got %b want 000", {done, busy, lsu_bus.mem_req});
    end
    tick();
    start = 1'b0;
    tests_run++;
    if ({lsu_bus.mem_req, busy, done} !== 3'b110) begin
      tests_failed++;
      $display("FAIL b2b_req2: req/busy/done got %b want 110", {lsu_bus.mem_req, busy, done});
    end
    lsu_bus.mem_ack   = 1'b1;
    lsu_bus.mem_rdata = 32'hAABB_CCDD;
    tick();
    lsu_bus.mem_ack = 1'b0;
    tests_run++;
    if (done !== 1'b1 || rdata !== 32'hFFFF_FFDD) begin
      tests_failed++;
      $display("FAIL b2b_done2: done %b rdata %h want 1 ffffffdd", done, rdata);
    end
    tick();
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout;
    is_store = 1'b0;
    funct3   = 3'b010;
    addr     = 32'h0000_5000;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tests_run++;
      if ({lsu_bus.mem_req, done} !== 2'b10) begin
        tests_failed++;
        $display("FAIL to_req[%0d]: req/done got %b want 10", j, {lsu_bus.mem_req, done});
      end
      tick();
    end
    tests_run++;
    if ({done, timeout, lsu_bus.mem_req} !== 3'b110 || rdata !== 32'hFFFF_FFDD) begin
      tests_failed++;
      $display("FAIL to_expire: done/timeout/req %b rdata %h want 110 ffffffdd",
               {done, timeout, lsu_bus.mem_req}, rdata);
    end
    tick();
    addr  = 32'h0000_5004;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j == 3) begin
        lsu_bus.mem_ack   = 1'b1;
        lsu_bus.mem_rdata = 32'hCAFE_F00D;
      end
      tick();
    end
    lsu_bus.mem_ack = 1'b0;
    tests_run++;
    if ({done, timeout} !== 2'b10 || rdata !== 32'hCAFE_F00D) begin
      tests_failed++;
      $display("FAIL to_ack_wins: done/timeout %b rdata %h want 10 cafef00d",
               {done, timeout}, rdata);
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid;
    is_store = 1'b0;
    funct3   = 3'b010;
    addr     = 32'h0000_4000;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tests_run++;
    if (lsu_bus.mem_req !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_req: got %b want 1", lsu_bus.mem_req);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if ({busy, done, lsu_bus.mem_req, lsu_bus.mem_we} !== 4'b0 || rdata !== 32'h0 ||
        lsu_bus.mem_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL rstmid_clear: busy/done/req/we %b rdata %h addr %h want 0000 0 0",
               {busy, done, lsu_bus.mem_req, lsu_bus.mem_we}, rdata, lsu_bus.mem_addr);
    end
    lsu_bus.mem_ack   = 1'b1;
    lsu_bus.mem_rdata = 32'h1234_5678;
    for (int j = 0; j < 3; j++) begin
      if (j == 2) lsu_bus.mem_ack = 1'b0;
      tick();
      tests_run++;
      if ({busy, done, lsu_bus.mem_req} !== 3'b000 || rdata !== 32'h0) begin
        tests_failed++;
        $display("FAIL rstmid_ack[%0d]: busy/done/req %b rdata %h want 000 0", j,
                 {busy, done, lsu_bus.mem_req}, rdata);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset             = 1'b1;
    start             = 1'b0;
    is_store          = 1'b0;
    funct3            = 3'b000;
    addr              = 32'h0;
    wdata             = 32'h0;
    lsu_bus.mem_ack   = 1'b0;
    lsu_bus.mem_rdata = 32'h0;
    test_reset();
    test_load();
    test_store();
    test_fault();
    test_back_to_back();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU. Takes the ALU result as the effective address, together with rs2 store data and funct3.
- Performs one RV32I load (LB/LH/LW/LBU/LHU) or store (SB/SH/SW) over a req/ack data-memory handshake.
- Returns aligned, extended load data to writeback with a one-cycle done pulse.
- Multi-cycle: the core stalls while busy=1.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles mem_req stays high without mem_ack. Used only when the optional feature is enabled.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request pulse from execute; accepted only when busy=0
- is_store  input  1  1=store, 0=load
- funct3  input  3  RV32I width/sign code
- addr  input  32  effective address (ALU result)
- wdata  input  32  store data (rs2)
- busy  output  1  high from the cycle after an accepted start through the done cycle
- done  output  1  one-cycle completion pulse
- rdata  output  32  extended load data; valid with done, held until the next done
- misaligned  output  1  valid with done; address not naturally aligned
- illegal  output  1  valid with done; unsupported funct3
- mem_req  output  1  memory request, held until acknowledged
- mem_we  output  1  write enable, valid with mem_req
- mem_addr  output  32  word address, {addr[31:2],2'b00}
- mem_wmask  output  4  byte-lane write enables
- mem_wdata  output  32  lane-replicated store data
- mem_ack  input  1  memory completion; sampled only while mem_req=1
- mem_rdata  input  32  read word; valid in the mem_ack cycle
- timeout  output  1  valid with done; only exists under LSU_TIMEOUT_EN

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0, including rdata, mem_* and flags.
- Reset mid-access: mem_req drops at that edge; any later mem_ack is ignored.
- Start accepted (IDLE, start=1): latch addr, wdata, funct3 and is_store. Input changes after that edge are ignored.
- start while busy=1: ignored; no queueing.
- States: IDLE, ACCESS, DONE.
  - IDLE -> ACCESS on an accepted, legal, aligned start.
  - IDLE -> DONE on an accepted start that is illegal or misaligned. No mem_req is issued; the flag is set; rdata is unchanged.
  - ACCESS: mem_req=1 with mem_addr, mem_we, mem_wmask and mem_wdata stable. On mem_ack=1, capture the extended load data (loads only) and go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. A start in this cycle is ignored.
- Latency: start at cycle N; mem_req from N+1; ack at cycle M gives done at M+1. Minimum 2 cycles; 1 cycle for a fault.
- Legal funct3:
  - loads: 000, 001, 010, 100, 101
  - stores: 000, 001, 010
  - all others set illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00. Otherwise misaligned. If illegal, misaligned=0.
- Store lanes (b = addr[1:0]):
  - SB: mem_wmask=1<<b; mem_wdata={4{wdata[7:0]}}.
  - SH: mem_wmask=0011 (b=00) or 1100 (b=10); mem_wdata={2{wdata[15:0]}}.
  - SW: mem_wmask=1111; mem_wdata=wdata.
- Loads: mem_we=0, mem_wmask=0000. Extract the byte/half at offset b from mem_rdata:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Stores: rdata unchanged at done.
- Flags: all cleared on every new accepted start.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Enabled:
  - A counter clears on entering ACCESS and increments each ACCESS cycle without mem_ack.
  - When the count reaches TIMEOUT_CYCLES, mem_req drops and the unit enters DONE with timeout=1; rdata is unchanged.
  - mem_ack in the same cycle as the limit wins: normal completion, timeout=0.
- Disabled: no timeout port and no counter; ACCESS waits indefinitely.

Test Plan:
- LB at addr=0x1003, mem_rdata=0x80FF_1234, ack 1 cycle after req -> mem_addr=0x1000, mem_we=0; done 2 cycles after start; rdata=0xFFFF_FF80. Repeat as LBU -> 0x0000_0080.
- SH at addr=0x2002, wdata=0x1234_ABCD, ack after 3 wait cycles -> mem_wmask=1100, mem_wdata=0xABCD_ABCD, held stable for all 4 req cycles; done=1 once; busy low after done.
- LW at addr=0x3001 -> no mem_req; done 1 cycle after start with misaligned=1; rdata keeps its prior value. funct3=011 load -> illegal=1, misaligned=0.
- start asserted every cycle during an access -> exactly one mem_req transaction and one done; the second start is accepted only after returning to IDLE.
- reset asserted while mem_req=1, then mem_ack pulses -> mem_req=0 after the reset edge; no done; all outputs 0.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> mem_req high 4 cycles, then done with timeout=1. Same setup with ack on the 4th cycle -> timeout=0 and valid data.
